// File: rtl/upsp_ac_wr_framer.sv
// Write-side output framer for the upscaled pixel stream.
// Buffers incoming pixels in a small FIFO. At push time it tags each pixel
// with frame position markers (sof/eol/eof), taken from the raster column and
// row counters. It re-emits the pixels with start-of-frame (tuser) and
// end-of-line (tlast) markers, and pulses frame_done after the final pixel
// of a frame has been popped.
module upsp_ac_wr_framer #(
  parameter int DST_WIDTH  = 3840,
  parameter int DST_HEIGHT = 2160,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] upsp_ac_wdata,
  input  logic        upsp_ac_wvalid,
  output logic        ac_upsp_wready,
  output logic [23:0] m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tuser,
  output logic        m_tlast,
  output logic        frame_done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int COL_W = (DST_WIDTH  > 1) ? $clog2(DST_WIDTH)  : 1;
  localparam int ROW_W = (DST_HEIGHT > 1) ? $clog2(DST_HEIGHT) : 1;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(DST_WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(DST_HEIGHT - 1);

  // One buffered pixel together with its frame position tags.
  typedef struct packed {
    logic [23:0] data;
    logic        sof;
    logic        eol;
    logic        eof;
  } entry_t;

  entry_t           mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             frame_done_q, frame_done_d;

  entry_t push_entry;
  entry_t head;
  logic   empty;
  logic   push;
  logic   pop;

  // Ready is taken from the registered count only. A pop in the same cycle
  // therefore never opens a slot for a push into a full FIFO.
  assign empty          = (count_q == '0);
  assign ac_upsp_wready = (count_q != FULL_CNT);
  assign m_tvalid       = !empty;
  assign push           = upsp_ac_wvalid && ac_upsp_wready;
  assign pop            = m_tvalid && m_tready;

  // Head fields are forced to zero while empty so the outputs never show stale entries.
  assign head       = empty ? '0 : mem_q[rd_ptr_q];
  assign m_tdata    = head.data;
  assign m_tuser    = head.sof;
  assign m_tlast    = head.eol;
  assign frame_done = frame_done_q;

  // Tag the incoming pixel and compute the next raster position, pointers and count.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    push_entry.data = upsp_ac_wdata;
    push_entry.sof  = (col_q == '0) && (row_q == '0);
    push_entry.eol  = (col_q == LAST_COL);
    push_entry.eof  = push_entry.eol && (row_q == LAST_ROW);

    col_d        = col_q;
    row_d        = row_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    frame_done_d = pop && head.eof;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (push_entry.eol) begin
        col_d = '0;
        row_d = push_entry.eof ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register with synchronous reset. Reset discards all buffered pixels.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      col_q        <= '0;
      row_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      col_q        <= col_d;
      row_q        <= row_d;
      frame_done_q <= frame_done_d;
    end
  end

  // FIFO storage write.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; the count/pointers decide validity, so contents are don't-care.
    if (push) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

endmodule

// File: tb/tb_upsp_ac_wr_framer.sv
// Self-checking bench for upsp_ac_wr_framer (4x2 frames, 4-entry FIFO).
// The reference model is a queue of expected pixels. Each pixel's tags come
// from its index within the frame. The model is checked against the DUT on
// every falling edge. Directed literal checks pin the model.
module tb_upsp_ac_wr_framer;

  localparam int W = 4;
  localparam int H = 2;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] upsp_ac_wdata = '0;
  logic        upsp_ac_wvalid = 1'b0;
  logic        ac_upsp_wready;
  logic [23:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic        m_tuser;
  logic        m_tlast;
  logic        frame_done;

  int total = 0;
  int bad   = 0;

  upsp_ac_wr_framer #(
    .DST_WIDTH (W),
    .DST_HEIGHT(H),
    .FIFO_DEPTH(D)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .upsp_ac_wdata (upsp_ac_wdata),
    .upsp_ac_wvalid(upsp_ac_wvalid),
    .ac_upsp_wready(ac_upsp_wready),
    .m_tdata       (m_tdata),
    .m_tvalid      (m_tvalid),
    .m_tready      (m_tready),
    .m_tuser       (m_tuser),
    .m_tlast       (m_tlast),
    .frame_done    (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expected output pixels in order, tagged by position in frame.
  typedef struct {
    logic [23:0] d;
    bit          sof;
    bit          eol;
    bit          eof;
  } ent_t;

  ent_t        q[$];
  int unsigned pix_idx  = 0;
  bit          fd_exp   = 1'b0;
  int          eof_pops = 0;
  int          fd_seen  = 0;
  bit          chk_en   = 1'b0;
  bit          rnd_mode = 1'b0;

  always @(posedge clk) begin
    bit do_push;
    bit do_pop;
    int pos;
    if (rst) begin
      q.delete();
      pix_idx = 0;
      fd_exp  = 1'b0;
    end else begin
      do_push = upsp_ac_wvalid && (q.size() != D);
      do_pop  = (q.size() != 0) && m_tready;
      fd_exp  = do_pop && q[0].eof;
      if (do_pop) begin
        if (q[0].eof) eof_pops++;
        void'(q.pop_front());
      end
      if (do_push) begin
        pos = int'(pix_idx % (W * H));
        q.push_back('{upsp_ac_wdata, pos == 0, (pos % W) == W - 1, pos == W * H - 1});
        pix_idx++;
      end
    end
  end

  // Compare the DUT against the model on every falling edge.
  always @(negedge clk) begin
    ent_t e;
    if (chk_en) begin
      e = '{24'h0, 1'b0, 1'b0, 1'b0};
      if (q.size() != 0) e = q[0];
      check("m_tvalid", {31'b0, m_tvalid}, {31'b0, q.size() != 0});
      check("wready", {31'b0, ac_upsp_wready}, {31'b0, q.size() != D});
      check("m_tdata", {8'b0, m_tdata}, {8'b0, e.d});
      check("m_tuser", {31'b0, m_tuser}, {31'b0, e.sof});
      check("m_tlast", {31'b0, m_tlast}, {31'b0, e.eol});
      check("frame_done", {31'b0, frame_done}, {31'b0, fd_exp});
      if (frame_done) fd_seen++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_mode) m_tready = ($urandom_range(0, 1) == 1);
  endtask

  // Present a pixel and hold it until accepted. Valid stays high on return.
  task automatic push_one(input logic [23:0] d);
    bit acc;
    upsp_ac_wdata  = d;
    upsp_ac_wvalid = 1'b1;
    acc = 1'b0;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clk);
      acc = ac_upsp_wready;
      tick();
    end
    if (!acc) check("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_wready"}, {31'b0, ac_upsp_wready}, 32'd1);
    check({tag, "_tvalid"}, {31'b0, m_tvalid}, 32'd0);
    check({tag, "_tdata"}, {8'b0, m_tdata}, 32'd0);
    check({tag, "_tuser"}, {31'b0, m_tuser}, 32'd0);
    check({tag, "_tlast"}, {31'b0, m_tlast}, 32'd0);
    check({tag, "_frame_done"}, {31'b0, frame_done}, 32'd0);
  endtask

  initial begin
    int fd_base;
    int eof_base;
    int n;

    // Reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    tick();

    // Test 1: one 4x2 frame back to back, downstream always ready
    m_tready       = 1'b1;
    upsp_ac_wdata  = 24'h000001;
    upsp_ac_wvalid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (i < 7) upsp_ac_wdata = 24'(i + 2);
      else upsp_ac_wvalid = 1'b0;
      @(negedge clk);
      if (i < 8) begin
        check("t1_data", {8'b0, m_tdata}, i + 1);
        check("t1_tuser", {31'b0, m_tuser}, {31'b0, i == 0});
        check("t1_tlast", {31'b0, m_tlast}, {31'b0, (i == 3) || (i == 7)});
        check("t1_fd_low", {31'b0, frame_done}, 32'd0);
      end else begin
        check("t1_fd_pulse", {31'b0, frame_done}, 32'd1);
        check("t1_empty", {31'b0, m_tvalid}, 32'd0);
      end
    end
    tick();
    @(negedge clk);
    check("t1_fd_one_cycle", {31'b0, frame_done}, 32'd0);

    // Test 2: fill with downstream stalled
    m_tready       = 1'b0;
    upsp_ac_wvalid = 1'b1;
    upsp_ac_wdata  = 24'h000011;
    for (int k = 0; k < 4; k++) begin
      tick();
      upsp_ac_wdata = 24'(24'h12 + k);
    end
    @(negedge clk);
    check("t2_full_wready", {31'b0, ac_upsp_wready}, 32'd0);
    check("t2_head", {8'b0, m_tdata}, 32'h11);
    tick();
    @(negedge clk);
    check("t2_still_full", {31'b0, ac_upsp_wready}, 32'd0);

    // Test 3: pop and offered push on a full FIFO in the same cycle
    m_tready = 1'b1;
    tick();
    @(negedge clk);
    check("t3_wready_back", {31'b0, ac_upsp_wready}, 32'd1);
    check("t3_head", {8'b0, m_tdata}, 32'h12);
    tick();
    upsp_ac_wvalid = 1'b0;
    repeat (6) tick();
    @(negedge clk);
    check("t3_drained", {31'b0, m_tvalid}, 32'd0);

    // Reset during a frame with two pixels buffered
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_tready = 1'b1;
    push_one(24'h000021);
    push_one(24'h000022);
    push_one(24'h000023);
    upsp_ac_wvalid = 1'b0;
    tick();
    tick();
    m_tready = 1'b0;
    push_one(24'h000024);
    push_one(24'h000025);
    upsp_ac_wvalid = 1'b0;
    @(negedge clk);
    check("rst_pre_head", {8'b0, m_tdata}, 32'h24);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("midrst");
    push_one(24'h000031);
    upsp_ac_wvalid = 1'b0;
    @(negedge clk);
    check("midrst_sof_data", {8'b0, m_tdata}, 32'h31);
    check("midrst_sof_tuser", {31'b0, m_tuser}, 32'd1);
    m_tready = 1'b1;
    tick();
    tick();

    // Idle after reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      @(negedge clk);
      check("idle_tvalid", {31'b0, m_tvalid}, 32'd0);
      check("idle_fd", {31'b0, frame_done}, 32'd0);
      check("idle_wready", {31'b0, ac_upsp_wready}, 32'd1);
    end

    // Random ready/valid over three frames
    rst = 1'b1;
    tick();
    rst = 1'b0;
    fd_base  = fd_seen;
    eof_base = eof_pops;
    rnd_mode = 1'b1;
    for (int p = 0; p < 3 * W * H; p++) begin
      if ($urandom_range(0, 1) == 1) begin
        upsp_ac_wvalid = 1'b0;
        tick();
      end
      push_one(24'($urandom));
    end
    upsp_ac_wvalid = 1'b0;
    rnd_mode = 1'b0;
    m_tready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    if (q.size() != 0) check("drain_timeout", 32'd0, 32'd1);
    tick();
    tick();
    check("rnd_frame_done_pulses", fd_seen - fd_base, 32'd3);
    check("rnd_model_eof_pops", eof_pops - eof_base, 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/upsp_ac_wr_framer.md
# upsp_ac_wr_framer

Write-side output framer sitting directly downstream of `bicubic_top`: consumes the 24-bit upscaled pixel stream (`upsp_ac_wdata` / `upsp_ac_wvalid`, with backpressure `ac_upsp_wready`), buffers it in a small FIFO and re-emits it as a framed stream with start-of-frame and end-of-line markers for the access controller's write path. Raster position is tracked with column and row counters sized to the destination image. A per-frame completion pulse is raised when the final pixel of a frame leaves the block.

## Interface
- `DST_WIDTH`, default 3840: destination pixels per line.
- `DST_HEIGHT`, default 2160: destination lines per frame.
- `FIFO_DEPTH`, default 4: buffer entries, power of two, ≥2.
- `clk  input  1`: single clock, all logic on rising edge.
- `rst  input  1`: synchronous, active-high reset.
- `upsp_ac_wdata  input  24`: pixel from upsampler, {R,G,B}.
- `upsp_ac_wvalid  input  1`: pixel valid.
- `ac_upsp_wready  output  1`: framer can accept a pixel.
- `m_tdata  output  24`: outgoing pixel.
- `m_tvalid  output  1`: outgoing pixel valid.
- `m_tready  input  1`: downstream accepts.
- `m_tuser  output  1`: first pixel of frame (row 0, col 0).
- `m_tlast  output  1`: last pixel of a line (col DST_WIDTH-1).
- `frame_done  output  1`: one-cycle pulse after last pixel of frame is popped.

## Operation
- Push = `upsp_ac_wvalid && ac_upsp_wready`; pop = `m_tvalid && m_tready`.
- `ac_upsp_wready = (count != FIFO_DEPTH)`, derived only from registered count; a pop in the same cycle does not allow a push into a full FIFO.
- Each entry stores 27 bits: data, sof, eol, eof. Tags computed at push from counters: sof = (col==0 && row==0); eol = (col==DST_WIDTH-1); eof = eol && (row==DST_HEIGHT-1).
- On push: col increments; at DST_WIDTH-1 col wraps to 0 and row increments; at row DST_HEIGHT-1 with eol, row wraps to 0 (next push is sof of next frame). No push → counters hold.
- `m_tvalid = (count != 0)`; `m_tdata/m_tuser/m_tlast` = head entry fields; zero when empty.
- Simultaneous push and pop (non-full, non-empty, or empty-with-push not yet visible): count unchanged, both pointers advance.
- Pointers are log2(FIFO_DEPTH) bits, wrap naturally; count is log2(FIFO_DEPTH)+1 bits.
- `frame_done` registered: 1 in cycle after a pop whose entry has eof=1; else 0.
- Reset mid-frame: pointers, count, col, row cleared; buffered pixels discarded; next push tagged sof.

## Timing
- Reset values: `ac_upsp_wready`=1 (count 0), `m_tvalid`=0, `m_tdata`=0, `m_tuser`=0, `m_tlast`=0, `frame_done`=0.
- Latency: pixel pushed at edge N is presented on `m_tdata` with `m_tvalid`=1 after edge N (one cycle), if FIFO was empty.
- Throughput: one pixel/cycle sustained when `m_tready` held high.
- Full: after FIFO_DEPTH pushes with no pops, `ac_upsp_wready`=0 from next cycle; upstream must hold data/valid stable (upstream responsibility, not checked).
- `m_tvalid` never deasserts while head unpopped; head fields stable until popped.
- `frame_done` asserted exactly 1 cycle, 1 cycle after eof pop.

## Test plan
- DST_WIDTH=4, DST_HEIGHT=2, m_tready=1, push 8 pixels 0x000001..0x000008 back-to-back -> output same sequence 1 cycle later; tuser on 0x000001 only; tlast on 0x000004, 0x000008; frame_done pulse cycle after 0x000008 pops.
- FIFO_DEPTH=4, m_tready=0, push continuously -> exactly 4 accepted, `ac_upsp_wready`=0 from cycle after 4th push; raise m_tready -> order preserved, wready returns 1 cycle after first pop.
- Full FIFO with push and pop same cycle -> push refused, count drops to 3, no data loss or duplication.
- Random m_tready (50%) and upsp_ac_wvalid over 3 frames -> output equals input stream, tuser/tlast at correct positions every frame, 3 frame_done pulses.
- Assert rst after 5 pixels of a frame with 2 buffered -> all outputs at reset values next cycle; next pushed pixel emerges with tuser=1.
- Idle after reset (no valid) for 20 cycles -> m_tvalid=0, frame_done=0, wready=1 throughout.
